// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The unit drives ready/busy/done and the HI/LO pair; the pipeline drives the rest.
`timescale 1ns/1ps

interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req_valid, op, a, b, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, op, a, b, flush,
        output req_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Iterative multiply/divide unit owning HI/LO; shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to replace the shift-add multiply with a single-cycle multiplier.
`timescale 1ns/1ps

module mdu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  resetn,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic               is_mul, neg_res, neg_rem, done_q;

    logic               accept, commit, last_iter;
    logic               is_signed, b_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    assign accept    = bus.req_valid && (state == IDLE) && !bus.flush;
    assign commit    = (state == FIX) && !bus.flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign cnt_inc   = (cnt == CNT_W'(WIDTH)) ? cnt : cnt + CNT_W'(1);

    // Signed ops run on magnitudes; MIN maps onto itself, read as 2^(WIDTH-1).
    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign b_zero    = (bus.b == '0);
    assign mag_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd});
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_res ? -prod : prod;

    always_comb begin
        fix_hi = neg_rem ? -acc_hi : acc_hi;
        fix_lo = neg_res ? -acc_lo : acc_lo;
        if (is_mul) begin
            {fix_hi, fix_lo} = prod_fix;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

    assign ext_a     = {{WIDTH{is_signed & bus.a[WIDTH-1]}}, bus.a};
    assign ext_b     = {{WIDTH{is_signed & bus.b[WIDTH-1]}}, bus.b};
    assign fast_prod = ext_a * ext_b;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush beats everything outside IDLE, including a commit due on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
`ifdef MDU_FAST_MUL_EN
                        OP_MULT, OP_MULTU: state_nxt = FIX;
`else
                        OP_MULT, OP_MULTU: state_nxt = MUL;
`endif
                        OP_DIV, OP_DIVU:   state_nxt = b_zero ? FIX : DIV;
                        default:           state_nxt = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q    <= '0;
            lo_q    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            cnt     <= '0;
            is_mul  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        case (bus.op)
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            OP_MULT, OP_MULTU: begin
                                is_mul <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                                {acc_hi, acc_lo} <= fast_prod;
                                neg_res <= 1'b0;
                                neg_rem <= 1'b0;
`else
                                acc_hi  <= '0;
                                acc_lo  <= mag_b;
                                opnd    <= mag_a;
                                neg_res <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_rem <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                is_mul <= 1'b0;
                                if (b_zero) begin
                                    acc_hi  <= bus.a;
                                    acc_lo  <= '1;
                                    neg_res <= 1'b0;
                                    neg_rem <= 1'b0;
                                end else begin
                                    acc_hi  <= '0;
                                    acc_lo  <= mag_a;
                                    opnd    <= mag_b;
                                    neg_res <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                    neg_rem <= is_signed & bus.a[WIDTH-1];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt_inc;
                end
                // Quotient bits enter at the bottom of acc_lo as dividend bits leave the top.
                DIV: begin
                    acc_hi <= div_ok ? div_sub : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    cnt    <= cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: fixed vectors, hand-written flush/reset sequences,
// and random ops checked against a plain-arithmetic 64-bit reference model.
`timescale 1ns/1ps

module tb_mdu;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    mdu_if #(.WIDTH(W)) bus ();

    mdu #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives a request for exactly one edge, then scrambles the operands.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    // Returns at the negedge of the done cycle; lat counts edges after acceptance.
    task automatic waitDone(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
            if (bus.busy === 1'b1) busyCnt++;
            @(posedge clk);
            lat++;
        end
        lat = -1;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int elat);
        int lat, bc;
        applyStimulus(op, a, b);
        waitDone(lat, bc);
        checkOutput({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        checkOutput({tag, " lo"}, 64'(bus.lo), 64'(elo));
        checkOutput({tag, " latency"}, 64'(lat), 64'(elat));
        checkOutput({tag, " busy cycles"}, 64'(bc), 64'(elat));
        checkOutput({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] ehi, output logic [31:0] elo, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] r64, q64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ehi = '0;
        elo = '0;
        lat = DIV_LAT;
        if (op == 3'd0 || op == 3'd1) begin
            r64 = (op == 3'd0) ? sa * sb : ua * ub;
            ehi = r64[63:32];
            elo = r64[31:0];
            lat = MUL_LAT;
        end else if (b == 32'd0) begin
            ehi = a;
            elo = 32'hFFFF_FFFF;
            lat = 1;
        end else begin
            q64 = (op == 3'd2) ? sa / sb : ua / ub;
            r64 = (op == 3'd2) ? sa % sb : ua % ub;
            elo = q64[31:0];
            ehi = r64[31:0];
        end
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, ehi, elo;
        logic [2:0]  rop;
        int          elat, dcnt;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, DIV_LAT};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
        vecs[5]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{3'd2, 32'h0000_0064, 32'h0000_0003, 32'h0000_0001, 32'h0000_0021, DIV_LAT};
        vecs[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
        vecs[8]  = '{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};

        bus.req_valid = 1'b0;
        bus.op = 3'd0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset ready", 64'(bus.req_ready), 64'd1);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // vec2 -> vec3 issues DIVU in the done cycle of the DIV (back-to-back).
        for (int i = 0; i < 11; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].lat);
        end

        @(negedge clk);
        checkOutput("done single cycle", 64'(bus.done), 64'd0);

        applyStimulus(3'd4, 32'h1234_5678, 32'h0);
        checkOutput("mthi hi", 64'(bus.hi), 64'h1234_5678);
        checkOutput("mthi no done", 64'(bus.done), 64'd0);
        checkOutput("mthi ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        applyStimulus(3'd5, 32'hCAFE_F00D, 32'h0);
        checkOutput("mtlo lo", 64'(bus.lo), 64'hCAFE_F00D);
        checkOutput("mtlo hi kept", 64'(bus.hi), 64'h1234_5678);
        @(negedge clk);
        applyStimulus(3'd6, 32'hDEAD_BEEF, 32'h1);
        checkOutput("op6 ready", 64'(bus.req_ready), 64'd1);
        checkOutput("op6 hi/lo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);

        // Flush a DIV 100/3 so that the flush is sampled on E10.
        @(negedge clk);
        applyStimulus(3'd2, 32'd100, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checkOutput("flush ready", 64'(bus.req_ready), 64'd1);
        checkOutput("flush hi/lo kept", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        checkOutput("flush no done", 64'(dcnt), 64'd0);

        bus.flush = 1'b1;
        applyStimulus(3'd3, 32'd9, 32'd0);
        bus.flush = 1'b0;
        checkOutput("flush blocks accept", 64'(bus.req_ready), 64'd1);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        checkOutput("blocked req no done", 64'(dcnt), 64'd0);
        checkOutput("blocked req hi/lo", {bus.hi, bus.lo}, 64'h1234_5678_CAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            refModel(rop, ra, rb, ehi, elo, elat);
            runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ehi, elo, elat);
        end

        runOp("pre-reset", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        checkOutput("async reset done", 64'(bus.done), 64'd0);
        checkOutput("async reset ready", 64'(bus.req_ready), 64'd1);
        checkOutput("async reset busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post-reset idle", {bus.hi, bus.lo}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the execute stage. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO alongside the single-cycle ALU and stalls the pipeline through `busy` while an operation is in flight. Results commit atomically to HI/LO when the operation completes. An in-flight operation can be cancelled by the exception/flush path without disturbing HI/LO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.
- `CNT_W`, `$clog2(WIDTH)+1`, iteration counter width; derived, do not override.

- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: reset; asynchronous, active-low.
- `req_valid` in 1: request present on `op`/`a`/`b`.
- `req_ready` out 1: unit idle and accepting; reset 1.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- `a` in WIDTH: multiplicand or dividend; source value for MTHI/MTLO.
- `b` in WIDTH: multiplier or divisor.
- `flush` in 1: abort the in-flight operation; suppresses acceptance this cycle.
- `busy` out 1: equals `!req_ready`; reset 0.
- `done` out 1: one-cycle pulse, high in the cycle new HI/LO first become visible; reset 0.
- `hi` out WIDTH: HI register; reset 0.
- `lo` out WIDTH: LO register; reset 0.

## Operation
- **States.** IDLE, MUL, DIV, FIX.
- **Accept.** A request is accepted on a rising edge when `req_valid && req_ready && !flush`. Operands are latched at acceptance; the unit does not watch `a`/`b` afterwards.
- **MTHI/MTLO.** Writes `hi`/`lo` on the accepting edge and stays in IDLE. `done` is not pulsed.
- **Signed ops (MULT/DIV).** Operands are converted to magnitudes, each `WIDTH` bits and treated as unsigned, so |MIN| = 2^(WIDTH-1). The sign flags are latched.
- **MUL.** Shift-add, one multiplier bit per cycle, `WIDTH` cycles, producing a 2·WIDTH-bit product. Then FIX: the product is negated if the operand signs differ and written as `{hi,lo}`.
- **DIV.** Restoring division, one quotient bit per cycle, `WIDTH` cycles. Then FIX: the quotient is negated if the signs differ, and the remainder takes the dividend's sign. `lo` = quotient, `hi` = remainder.
- **Divide by zero (`b`==0, DIV or DIVU).** No iteration is performed. `lo` = all ones, `hi` = `a` unmodified, committed on the edge after acceptance. No exception is raised.
- **Signed overflow (MIN / -1).** Falls out of the magnitude path: `lo` = MIN, `hi` = 0. No exception is raised.
- **Flush.** In MUL, DIV or FIX, `flush` returns the unit to IDLE on the next edge. `hi`/`lo` are unchanged and `done` stays 0. If `flush` and a commit fall on the same edge, the flush wins. In IDLE, `flush` only blocks acceptance.
- **Reset mid-operation.** Everything returns to reset values immediately; partial results are discarded.

## Timing
- Acceptance edge is E0.
- **MUL/DIV.** The iteration counter runs `WIDTH` edges (E1..E`WIDTH`). FIX commits on edge E`WIDTH`+1. `done` is high for exactly the cycle after E`WIDTH`+1, and `req_ready` is high in that same cycle. Back-to-back issue is therefore possible with a latency of `WIDTH`+1 edges.
- **Divide by zero.** Commit and `done` occur at E1.
- **Fast multiply (macro below).** Commit and `done` occur at E1.
- **`busy`.** High from the cycle after E0 until the commit edge.
- **Visibility.** `hi`/`lo` are registered outputs, with no combinational path from the inputs.
- **Counter.** The counter saturates at `WIDTH` and never wraps.

## Configuration
- **`MDU_FAST_MUL_EN` defined.** MULT/MULTU use a single-cycle `WIDTH`×`WIDTH` multiplier with signed/unsigned selection. The result is committed at E1 and the MUL state is unused. DIV is unaffected.
- **`MDU_FAST_MUL_EN` undefined.** Multiplication uses the iterative shift-add path, with latency `WIDTH`+1.

## Test plan
Values below are for `WIDTH`=32 with the macro undefined.
- **Signed multiply.** MULT a=FFFFFFFF, b=00000002 -> hi=FFFFFFFF, lo=FFFFFFFE. `done` occurs in the cycle after E33; `busy` is high for 33 cycles.
- **Unsigned multiply.** MULTU with the same operands -> hi=00000001, lo=FFFFFFFE. With `MDU_FAST_MUL_EN` defined, the same result commits at E1.
- **Signed and unsigned divide.** DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIVU a=7, b=2 issued in the `done` cycle -> lo=3, hi=1.
- **Division boundary cases.**
  - DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
  - DIVU 5 / 0 -> lo=FFFFFFFF, hi=5, with `done` at E1.
- **Flush.** Run MTHI a=12345678, then DIV 100/3, and assert `flush` 10 cycles after E0.
  - Required: hi stays 12345678, no `done` pulse, and `req_ready`=1 on the next cycle.
  - A request presented together with `flush` is not accepted.
- **Reset mid-operation.** Drop `resetn` asynchronously in the middle of a MULTU. hi=lo=0, `done`=0 and `req_ready`=1 immediately, with no clock edge needed.
